// File: rtl/tex_to_rgb_pipe.sv
// rtl/tex_to_rgb_pipe.sv - multi-lane texel to RGB converter with CLUT lookup and credit-backed output FIFO
// Delay line re-aligns raw texels with CLUT returns; occupancy credits guarantee FIFO space.
module tex_to_rgb_pipe #(
   parameter int LANES     = 2,
   parameter int CLUT_LAT  = 1,
   parameter int OUT_DEPTH = CLUT_LAT + 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             GPU_REG_TexFormat,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [16*LANES-1:0]    in_data,
   input  logic [2*LANES-1:0]     in_ucoord_lsb,
   input  logic [LANES-1:0]       in_lane_mask,
   output logic [LANES-1:0]       lookup_valid,
   output logic [8*LANES-1:0]     lookup_index,
   input  logic [16*LANES-1:0]    clut_value,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [16*LANES-1:0]    out_pixel,
   output logic [LANES-1:0]       out_transparent,
   output logic [LANES-1:0]       out_lane_mask
);

   localparam int CW   = $clog2(OUT_DEPTH + 1);
   localparam int PW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int EW   = 18 * LANES;
   localparam int TAIL = CLUT_LAT - 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(OUT_DEPTH - 1);

   logic [CW-1:0]          occupancy;
   logic                   accept;
   logic                   push;
   logic                   pop;
   logic                   fifoEmpty;
   logic                   fifoFull;

   logic [CLUT_LAT-1:0]    dlValid;
   logic [CLUT_LAT-1:0]    dlDirect;
   logic [16*LANES-1:0]    dlData [CLUT_LAT];
   logic [LANES-1:0]       dlMask [CLUT_LAT];

   logic [16*LANES-1:0]    resPixel;
   logic [LANES-1:0]       resTransp;

   logic [EW-1:0]          fifoMem [OUT_DEPTH];
   logic [PW-1:0]          wrPtr;
   logic [PW-1:0]          rdPtr;
   logic [CW-1:0]          fifoCount;
   logic [EW-1:0]          headWord;

   // Credits count beats in the delay line plus FIFO, so a CLUT return always has a slot.
   assign in_ready = ~rst && (occupancy < DEPTH_C);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   always_comb begin
      lookup_valid = '0;
      lookup_index = '0;
      for (int i = 0; i < LANES; i++) begin
         lookup_valid[i] = accept && in_lane_mask[i] && ~GPU_REG_TexFormat[1];
         if (GPU_REG_TexFormat[0]) begin
            lookup_index[8*i +: 8] = in_ucoord_lsb[2*i] ? in_data[16*i+8 +: 8] : in_data[16*i +: 8];
         end else begin
            lookup_index[8*i +: 8] = {4'h0, in_data[16*i + 4*in_ucoord_lsb[2*i +: 2] +: 4]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dlValid <= '0;
      end else begin
         dlValid[0] <= accept;
         for (int k = 1; k < CLUT_LAT; k++) begin
            dlValid[k] <= dlValid[k-1];
         end
      end
   end

   // Payload needs no reset: it is only consumed when the matching valid bit is set.
   always_ff @(posedge clk) begin
      dlDirect[0] <= GPU_REG_TexFormat[1];
      dlData[0]   <= in_data;
      dlMask[0]   <= in_lane_mask;
      for (int k = 1; k < CLUT_LAT; k++) begin
         dlDirect[k] <= dlDirect[k-1];
         dlData[k]   <= dlData[k-1];
         dlMask[k]   <= dlMask[k-1];
      end
   end

   always_comb begin
      resPixel  = '0;
      resTransp = '0;
      for (int i = 0; i < LANES; i++) begin
         if (!dlMask[TAIL][i]) begin
            resPixel[16*i +: 16] = 16'h0000;
            resTransp[i]         = 1'b1;
         end else begin
            resPixel[16*i +: 16] = dlDirect[TAIL] ? dlData[TAIL][16*i +: 16] : clut_value[16*i +: 16];
            resTransp[i]         = ~|resPixel[16*i +: 15];
         end
      end
   end

   assign push      = dlValid[TAIL];
   assign fifoEmpty = (fifoCount == '0);
   assign fifoFull  = (fifoCount == DEPTH_C);
   assign out_valid = ~fifoEmpty;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (push) begin
            wrPtr <= (wrPtr == LAST_C) ? '0 : wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= (rdPtr == LAST_C) ? '0 : rdPtr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifoCount <= fifoCount + 1'b1;
            2'b01:   fifoCount <= fifoCount - 1'b1;
            default: fifoCount <= fifoCount;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem[wrPtr] <= {dlMask[TAIL], resTransp, resPixel};
      end
   end

   assign headWord        = fifoMem[rdPtr];
   assign out_pixel       = fifoEmpty ? '0 : headWord[16*LANES-1:0];
   assign out_transparent = fifoEmpty ? '0 : headWord[17*LANES-1:16*LANES];
   assign out_lane_mask   = fifoEmpty ? '0 : headWord[18*LANES-1:17*LANES];

   noPushWhenFull: assert property (@(posedge clk) disable iff (rst) !(push && fifoFull));

endmodule

// File: tb/tb_tex_to_rgb_pipe.sv
// tb/tb_tex_to_rgb_pipe.sv - randomized bench for tex_to_rgb_pipe with behavioural queue model
module tb_tex_to_rgb_pipe;

   localparam int LANES     = 2;
   localparam int CLUT_LAT  = 1;
   localparam int OUT_DEPTH = CLUT_LAT + 2;
   localparam int DW        = 16 * LANES;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [1:0]           GPU_REG_TexFormat;
   logic                 in_valid;
   logic                 in_ready;
   logic [DW-1:0]        in_data;
   logic [2*LANES-1:0]   in_ucoord_lsb;
   logic [LANES-1:0]     in_lane_mask;
   logic [LANES-1:0]     lookup_valid;
   logic [8*LANES-1:0]   lookup_index;
   logic [DW-1:0]        clut_value;
   logic                 out_valid;
   logic                 out_ready;
   logic [DW-1:0]        out_pixel;
   logic [LANES-1:0]     out_transparent;
   logic [LANES-1:0]     out_lane_mask;

   tex_to_rgb_pipe #(.LANES(LANES), .CLUT_LAT(CLUT_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk), .rst(rst), .GPU_REG_TexFormat(GPU_REG_TexFormat),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_ucoord_lsb(in_ucoord_lsb), .in_lane_mask(in_lane_mask),
      .lookup_valid(lookup_valid), .lookup_index(lookup_index), .clut_value(clut_value),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .out_transparent(out_transparent), .out_lane_mask(out_lane_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0]    pix;
      logic [LANES-1:0] tr;
      logic [LANES-1:0] mask;
      int               due;
   } beat_t;

   beat_t       expQ[$];
   logic [15:0] rom [256];
   int          nAssert = 0;
   int          nFail   = 0;
   int          cyc     = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] refIndex(input logic [1:0] fmt, input logic [15:0] w, input logic [1:0] u);
      int v;
      v = w;
      if (fmt == 2'd0) return 8'((v >> (4 * u)) % 16);
      return u[0] ? 8'(v / 256) : 8'(v % 256);
   endfunction

   function automatic beat_t refBeat(input logic [1:0] fmt, input logic [DW-1:0] d,
                                     input logic [2*LANES-1:0] u, input logic [LANES-1:0] m, input int due);
      beat_t b;
      logic [15:0] p;
      b.pix = '0; b.tr = '0; b.mask = m; b.due = due;
      for (int i = 0; i < LANES; i++) begin
         if (!m[i])          p = 16'h0000;
         else if (fmt >= 2)  p = d[16*i +: 16];
         else                p = rom[refIndex(fmt, d[16*i +: 16], u[2*i +: 2])];
         b.pix[16*i +: 16] = p;
         b.tr[i] = ((p & 16'h7FFF) == 16'h0000);
      end
      return b;
   endfunction

   // CLUT cache responder: returns rom[index] CLUT_LAT cycles after a request, junk otherwise.
   logic [LANES-1:0]   rspV [CLUT_LAT];
   logic [8*LANES-1:0] rspI [CLUT_LAT];
   logic [63:0]        junk;

   always @(posedge clk) begin
      for (int k = CLUT_LAT - 1; k > 0; k--) begin
         rspV[k] <= rspV[k-1];
         rspI[k] <= rspI[k-1];
      end
      rspV[0] <= lookup_valid;
      rspI[0] <= lookup_index;
      junk    <= {$urandom, $urandom};
   end

   always_comb begin
      clut_value = '0;
      for (int i = 0; i < LANES; i++) begin
         clut_value[16*i +: 16] = (rspV[CLUT_LAT-1][i] === 1'b1) ? rom[rspI[CLUT_LAT-1][8*i +: 8]]
                                                                 : junk[16*i +: 16];
      end
   end

   // Per-cycle compare against the queue model, sampled 2ns after inputs change.
   always begin : cmpProc
      logic             expReady;
      logic             expOv;
      logic             acc;
      logic [LANES-1:0] expLv;
      logic [8*LANES-1:0] expIdx;
      logic [8*LANES-1:0] idxMask;
      beat_t            h;
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
         chk("rst in_ready", in_ready, 0);
         chk("rst out_valid", out_valid, 0);
         chk("rst lookup_valid", lookup_valid, 0);
         expQ.delete();
      end else begin
         expReady = (expQ.size() < OUT_DEPTH);
         chk("in_ready", in_ready, expReady);
         expOv = (expQ.size() > 0) && (cyc >= expQ[0].due);
         chk("out_valid", out_valid, expOv);
         if (expOv) begin
            h = expQ[0];
            chk("out_pixel", out_pixel, h.pix);
            chk("out_transparent", out_transparent, h.tr);
            chk("out_lane_mask", out_lane_mask, h.mask);
         end
         acc = in_valid && expReady;
         expLv = '0; expIdx = '0; idxMask = '0;
         for (int i = 0; i < LANES; i++) begin
            expLv[i] = acc && in_lane_mask[i] && (GPU_REG_TexFormat < 2);
            expIdx[8*i +: 8] = refIndex(GPU_REG_TexFormat, in_data[16*i +: 16], in_ucoord_lsb[2*i +: 2]);
            idxMask[8*i +: 8] = {8{expLv[i]}};
         end
         chk("lookup_valid", lookup_valid, expLv);
         if (expLv != 0) chk("lookup_index", lookup_index & idxMask, expIdx & idxMask);
         if (expOv && out_ready) void'(expQ.pop_front());
         if (acc) expQ.push_back(refBeat(GPU_REG_TexFormat, in_data, in_ucoord_lsb, in_lane_mask,
                                         cyc + CLUT_LAT + 1));
      end
   end

   task automatic directed(input string nm, input logic [1:0] fmt, input logic [31:0] data,
                           input logic [3:0] u, input logic [1:0] mask, input logic [1:0] expLv,
                           input logic [15:0] expIdx, input logic [31:0] expPix, input logic [1:0] expTr);
      logic [15:0] m;
      @(negedge clk);
      GPU_REG_TexFormat = fmt; in_data = data; in_ucoord_lsb = u; in_lane_mask = mask;
      in_valid = 1'b1; out_ready = 1'b1;
      #3;
      chk({nm, " lookup_valid"}, lookup_valid, expLv);
      m = {{8{expLv[1]}}, {8{expLv[0]}}};
      if (expLv != 0) chk({nm, " lookup_index"}, lookup_index & m, expIdx & m);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #3;
      chk({nm, " out_valid"}, out_valid, 1);
      chk({nm, " out_pixel"}, out_pixel, expPix);
      chk({nm, " out_transparent"}, out_transparent, expTr);
      chk({nm, " out_lane_mask"}, out_lane_mask, mask);
   endtask

   task automatic randInputs();
      GPU_REG_TexFormat = 2'($urandom);
      in_data           = DW'({$urandom, $urandom});
      in_ucoord_lsb     = 4'($urandom);
      in_lane_mask      = 2'($urandom);
   endtask

   initial begin
      int cnt;
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      rom[8'h0B] = 16'h7FFF; rom[8'h01] = 16'h0000;
      rom[8'h5A] = 16'h1234; rom[8'hFF] = 16'h8000;
      rom[8'h0F] = 16'h03E0; rom[8'h10] = 16'h0000;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; GPU_REG_TexFormat = 2'd0;
      in_data = '0; in_ucoord_lsb = '0; in_lane_mask = '0;
      #3;
      chk("reset out_valid", out_valid, 0);
      chk("reset out_pixel", out_pixel, 0);
      chk("reset out_transparent", out_transparent, 0);
      chk("reset out_lane_mask", out_lane_mask, 0);
      chk("reset in_ready", in_ready, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      directed("4bpp",  2'd0, 32'h1234ABCD, 4'b1110, 2'b11, 2'b11, 16'h010B, 32'h0000_7FFF, 2'b10);
      directed("8bpp",  2'd1, 32'h00FF5AC3, 4'b0001, 2'b11, 2'b11, 16'hFF5A, 32'h8000_1234, 2'b10);
      directed("16bpp", 2'd2, 32'h7C008000, 4'b0000, 2'b11, 2'b00, 16'h0000, 32'h7C00_8000, 2'b01);
      directed("fmt3",  2'd3, 32'h00000421, 4'b0000, 2'b11, 2'b00, 16'h0000, 32'h0000_0421, 2'b10);
      directed("mask01",2'd0, 32'hFFFF00F0, 4'b0001, 2'b01, 2'b01, 16'h000F, 32'h0000_03E0, 2'b10);

      // Back-to-back alternating 4bpp/16bpp with out_ready held high.
      cnt = 0;
      for (int b = 0; b < 23; b++) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (b < 20) begin
            randInputs();
            GPU_REG_TexFormat = (b % 2 == 0) ? 2'd0 : 2'd2;
            in_lane_mask = 2'b11;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #3;
         if (out_valid) cnt++;
      end
      chk("b2b output count", cnt, 20);

      // Backpressure: exactly OUT_DEPTH accepts while out_ready is low.
      repeat (3) @(negedge clk);
      cnt = 0;
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         randInputs();
         in_valid = 1'b1; out_ready = 1'b0;
         #3;
         if (in_valid && in_ready) cnt++;
      end
      chk("accepts under backpressure", cnt, OUT_DEPTH);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) @(negedge clk);

      // Random traffic.
      for (int b = 0; b < 400; b++) begin
         @(negedge clk);
         randInputs();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) @(negedge clk);

      // Reset with beats in flight and queued.
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         randInputs();
         in_lane_mask = 2'b11; in_valid = 1'b1; out_ready = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;
      #3;
      chk("midrst out_valid", out_valid, 0);
      chk("midrst in_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #3;
      chk("post-rst in_ready", in_ready, 1);
      cnt = 0;
      for (int b = 0; b < 6; b++) begin
         @(negedge clk);
         #3;
         if (out_valid) cnt++;
      end
      chk("post-rst stale beats", cnt, 0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
